uart_rx_cfg: RTL

Parametrised UART receiver, the successor to the fixed 8N1 receiver.
- Configurable data width, parity mode and stop-bit count.
- Input synchroniser, oversampled bit timing with 3-sample majority vote, and false-start rejection.
- Framing and parity error flags.
- Sits between the board RX pin and the byte-stream consumers (command parser, RX FIFO); one-cycle valid strobe per frame.

---
 rtl/uart_rx_cfg.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with oversampled 3-sample majority voting,
// false-start rejection, and parity/framing error flags. Define UART_RX_BREAK_EN to add break_det.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
`ifdef UART_RX_BREAK_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [SCW-1:0] SC_A       = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_B       = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SC_DEC     = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SC_LAST    = SCW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic           PAR_ODD    = (PARITY == 1);
    localparam logic           STOP_LAST  = (STOP_BITS == 2);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_rx_cfg: CLK_FREQ / (BAUD_RATE * OVERSAMPLE) must be at least 2");
        end
        if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_os_check
            $error("uart_rx_cfg: OVERSAMPLE must be even and within 8..32");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2
            || STOP_BITS < 1 || STOP_BITS > 2) begin : g_frame_check
            $error("uart_rx_cfg: unsupported frame format parameters");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic                 sync1, rxs;
    logic [PW-1:0]        presc;
    logic                 tick;
    state_t               state;
    logic [SCW-1:0]       sc;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 samp_a, samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic                 armed, par_flag, frm_flag;
    logic                 maj, decide, frame_bad;
`ifdef UART_RX_BREAK_EN
    logic                 seen_one;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || tick) presc <= '0;
        else             presc <= presc + 1'b1;
    end

    assign tick      = (presc == PRESC_LAST);
    assign maj       = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign decide    = tick && (sc == SC_DEC);
    assign frame_bad = frm_flag | ~maj;

    // The sample counter keeps running across state changes so every bit is
    // decided at the same offset from the detected start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sc         <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shreg      <= '0;
            armed      <= 1'b1;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
            data_out   <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_BREAK_EN
            seen_one   <= 1'b0;
            break_det  <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_EN
            break_det <= 1'b0;
`endif
            if (tick && state != S_IDLE) begin
                sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
                if (sc == SC_A) samp_a <= rxs;
                if (sc == SC_B) samp_b <= rxs;
            end

            case (state)
                S_IDLE: begin
                    if (tick) begin
                        if (rxs) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= S_START;
                            sc    <= '0;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (decide) begin
                        if (maj) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (maj) seen_one <= 1'b1;
`endif
                        if (bit_idx == BIT_LAST) begin
                            state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        if ((^shreg ^ maj) != PAR_ODD) par_flag <= 1'b1;
`ifdef UART_RX_BREAK_EN
                        if (maj) seen_one <= 1'b1;
`endif
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (decide) begin
                        if (stop_idx == STOP_LAST) begin
`ifdef UART_RX_BREAK_EN
                            if (!seen_one && !maj) begin
                                break_det <= 1'b1;
                                armed     <= 1'b0;
                            end else
`endif
                            begin
                                data_out   <= shreg;
                                rx_valid   <= 1'b1;
                                parity_err <= par_flag;
                                frame_err  <= frame_bad;
                                if (frame_bad) armed <= 1'b0;
                            end
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            par_flag <= 1'b0;
                            frm_flag <= 1'b0;
`ifdef UART_RX_BREAK_EN
                            seen_one <= 1'b0;
`endif
                        end else begin
                            stop_idx <= 1'b1;
                            if (!maj) frm_flag <= 1'b1;
`ifdef UART_RX_BREAK_EN
                            if (maj) seen_one <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
